// File: rtl/main_clkgen_multi.sv
// rtl/main_clkgen_multi.sv - multi-channel rational clock-enable generator (rate cur_mhz/REF_MHZ of inclk0)
// Define CLKGEN_RAMP_EN to move speed by timed ramp steps; otherwise cur follows target one cycle later.
module main_clkgen_multi #(
   parameter int NUM_CH        = 2,
   parameter int REF_MHZ       = 50,
   parameter int DEFAULT_MHZ   = 25,
   parameter int RAMP_STEP_MHZ = 1,
   parameter int RAMP_INTERVAL = 4,
   localparam int SPD_W        = $clog2(REF_MHZ + 1)
) (
   input  logic                    inclk0,
   input  logic                    areset_n,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [2:0]              cfg_ch,
   input  logic [SPD_W-1:0]        cfg_mhz,
   output logic [NUM_CH-1:0]       ce,
   output logic [NUM_CH-1:0]       locked,
   output logic [NUM_CH*SPD_W-1:0] cur_mhz
);

   localparam int ACC_W = SPD_W + 1;
   localparam logic [SPD_W-1:0] REF_S = SPD_W'(REF_MHZ);
   localparam logic [SPD_W-1:0] DEF_S = SPD_W'((DEFAULT_MHZ > REF_MHZ) ? REF_MHZ : DEFAULT_MHZ);
   localparam logic [ACC_W-1:0] REF_A = ACC_W'(REF_MHZ);

   if (NUM_CH < 1 || NUM_CH > 8 || RAMP_STEP_MHZ < 1 || RAMP_INTERVAL < 1) begin : g_param_check
      $error("main_clkgen_multi: illegal parameter value");
   end

   logic [NUM_CH-1:0][SPD_W-1:0] cur_q, cur_d;
   logic [NUM_CH-1:0][SPD_W-1:0] tgt_q, tgt_d;
   logic [NUM_CH-1:0][ACC_W-1:0] acc_q, acc_d;
   logic [NUM_CH-1:0][ACC_W-1:0] sum;
   logic [NUM_CH-1:0]            ce_q, ce_d;
   logic [NUM_CH-1:0]            locked_q, locked_d;
   logic                         ready_q, ready_d;
   logic [SPD_W-1:0]             cfg_clamped;
   logic                         accept;

   assign cfg_clamped = (cfg_mhz > REF_S) ? REF_S : cfg_mhz;
   assign accept      = cfg_valid && ready_q;

`ifdef CLKGEN_RAMP_EN
   typedef enum logic [1:0] {ST_LOCK, ST_UP, ST_DOWN} state_e;

   localparam int TMR_W = (RAMP_INTERVAL > 1) ? $clog2(RAMP_INTERVAL) : 1;
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(RAMP_INTERVAL - 1);
   localparam logic [SPD_W-1:0] STEP_S  = SPD_W'((RAMP_STEP_MHZ > REF_MHZ) ? REF_MHZ : RAMP_STEP_MHZ);

   state_e           st_q [NUM_CH];
   state_e           st_d [NUM_CH];
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             tick;

   assign tick = (tmr_q == TMR_MAX);
`endif

   always_comb begin
      ready_d  = 1'b1;
      cur_d    = cur_q;
      tgt_d    = tgt_q;
      acc_d    = acc_q;
      sum      = '0;
      ce_d     = '0;
      locked_d = '0;
`ifdef CLKGEN_RAMP_EN
      tmr_d = tick ? '0 : tmr_q + 1'b1;
      st_d  = st_q;
`endif
      for (int ch = 0; ch < NUM_CH; ch++) begin
         // acc stays below REF, so one conditional subtract keeps it a true modulo
         sum[ch] = {1'b0, cur_q[ch]} + acc_q[ch];
         if (sum[ch] >= REF_A) begin
            acc_d[ch] = sum[ch] - REF_A;
            ce_d[ch]  = 1'b1;
         end else begin
            acc_d[ch] = sum[ch];
         end

         if (accept && cfg_ch == 3'(ch)) begin
            tgt_d[ch] = cfg_clamped;
         end

`ifdef CLKGEN_RAMP_EN
         case (st_q[ch])
            ST_UP: begin
               if (tgt_q[ch] < cur_q[ch]) begin
                  st_d[ch] = ST_DOWN;
               end else if (tgt_q[ch] == cur_q[ch]) begin
                  st_d[ch] = ST_LOCK;
               end else if (tick) begin
                  cur_d[ch] = cur_q[ch] + ((tgt_q[ch] - cur_q[ch] > STEP_S) ? STEP_S : tgt_q[ch] - cur_q[ch]);
                  if (cur_d[ch] == tgt_q[ch]) st_d[ch] = ST_LOCK;
               end
            end
            ST_DOWN: begin
               if (tgt_q[ch] > cur_q[ch]) begin
                  st_d[ch] = ST_UP;
               end else if (tgt_q[ch] == cur_q[ch]) begin
                  st_d[ch] = ST_LOCK;
               end else if (tick) begin
                  cur_d[ch] = cur_q[ch] - ((cur_q[ch] - tgt_q[ch] > STEP_S) ? STEP_S : cur_q[ch] - tgt_q[ch]);
                  if (cur_d[ch] == tgt_q[ch]) st_d[ch] = ST_LOCK;
               end
            end
            default: begin
               if (tgt_q[ch] > cur_q[ch]) begin
                  st_d[ch] = ST_UP;
               end else if (tgt_q[ch] < cur_q[ch]) begin
                  st_d[ch] = ST_DOWN;
               end
            end
         endcase
`else
         cur_d[ch] = tgt_q[ch];
`endif
         locked_d[ch] = (cur_d[ch] == tgt_d[ch]);
      end
   end

   always_ff @(posedge inclk0 or negedge areset_n) begin
      if (!areset_n) begin
         ready_q  <= 1'b0;
         cur_q    <= {NUM_CH{DEF_S}};
         tgt_q    <= {NUM_CH{DEF_S}};
         acc_q    <= '0;
         ce_q     <= '0;
         locked_q <= '0;
`ifdef CLKGEN_RAMP_EN
         tmr_q    <= '0;
         for (int ch = 0; ch < NUM_CH; ch++) st_q[ch] <= ST_LOCK;
`endif
      end else begin
         ready_q  <= ready_d;
         cur_q    <= cur_d;
         tgt_q    <= tgt_d;
         acc_q    <= acc_d;
         ce_q     <= ce_d;
         locked_q <= locked_d;
`ifdef CLKGEN_RAMP_EN
         tmr_q    <= tmr_d;
         st_q     <= st_d;
`endif
      end
   end

   assign cfg_ready = ready_q;
   assign ce        = ce_q;
   assign locked    = locked_q;
   assign cur_mhz   = cur_q;

endmodule

// File: tb/tb_main_clkgen_multi.sv
// tb/tb_main_clkgen_multi.sv - self-checking bench for main_clkgen_multi
// Honours CLKGEN_RAMP_EN the same way as the design.
`timescale 1ns/1ps
module tb_main_clkgen_multi;
   localparam int NUM_CH = 2;
   localparam int REF    = 50;
   localparam int DEF    = 25;
   localparam int STEP   = 1;
   localparam int INTV   = 4;
   localparam int SPD_W  = $clog2(REF + 1);

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    cfg_valid = 1'b0;
   logic                    cfg_ready;
   logic [2:0]              cfg_ch = '0;
   logic [SPD_W-1:0]        cfg_mhz = '0;
   logic [NUM_CH-1:0]       ce;
   logic [NUM_CH-1:0]       locked;
   logic [NUM_CH*SPD_W-1:0] cur_mhz;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   main_clkgen_multi #(
      .NUM_CH(NUM_CH), .REF_MHZ(REF), .DEFAULT_MHZ(DEF),
      .RAMP_STEP_MHZ(STEP), .RAMP_INTERVAL(INTV)
   ) dut (
      .inclk0(clk), .areset_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_mhz(cfg_mhz), .ce(ce), .locked(locked), .cur_mhz(cur_mhz)
   );

   function automatic int cur_of(input int ch);
      return int'(cur_mhz[ch*SPD_W +: SPD_W]);
   endfunction

   // Reference for the immediate-speed build: pulse k fires when the running
   // total of speed crosses k*REF, i.e. pulses so far = floor(total/REF).
   int     m_tgt [NUM_CH];
   int     m_cur [NUM_CH];
   longint m_tot [NUM_CH];
   bit     m_ce  [NUM_CH];
   bit     m_lock[NUM_CH];
   bit     m_ready;
   bit     m_take;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ready = 0;
         for (int c = 0; c < NUM_CH; c++) begin
            m_tgt[c] = DEF; m_cur[c] = DEF; m_tot[c] = 0; m_ce[c] = 0; m_lock[c] = 0;
         end
      end else begin
         m_take = cfg_valid && m_ready;
         for (int c = 0; c < NUM_CH; c++) begin
            m_ce[c]  = ((m_tot[c] + m_cur[c]) / REF) != (m_tot[c] / REF);
            m_tot[c] = m_tot[c] + m_cur[c];
            m_cur[c] = m_tgt[c];
            if (m_take && int'(cfg_ch) == c) m_tgt[c] = (int'(cfg_mhz) > REF) ? REF : int'(cfg_mhz);
            m_lock[c] = (m_cur[c] == m_tgt[c]);
         end
         m_ready = 1;
      end
   end

   task automatic apply_cfg(input int ch, input int mhz);
      cfg_ch    = 3'(ch);
      cfg_mhz   = SPD_W'(mhz);
      cfg_valid = 1'b1;
      @(posedge clk);
      #1 cfg_valid = 1'b0;
   endtask

   task automatic wait_lock(input int ch, input int val, input int bound, output bit ok, output int maxv);
      ok = 0; maxv = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (cur_of(ch) > maxv) maxv = cur_of(ch);
         if (cur_of(ch) == val && locked[ch]) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %0b expected 0", cfg_ready); end
      n_vec++; if (ce !== '0) begin n_err++; $display("FAIL reset_ce: got %b expected 00", ce); end
      n_vec++; if (locked !== '0) begin n_err++; $display("FAIL reset_locked: got %b expected 00", locked); end
      for (int c = 0; c < NUM_CH; c++) begin
         n_vec++; if (cur_of(c) !== DEF) begin n_err++; $display("FAIL reset_cur%0d: got %0d expected %0d", c, cur_of(c), DEF); end
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %0b expected 1", cfg_ready); end
      n_vec++; if (locked !== 2'b11) begin n_err++; $display("FAIL release_locked: got %b expected 11", locked); end
   endtask

   task automatic test_default_rate();
      int cnt = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         cnt += int'(ce[0]);
         n_vec++;
         if (ce[0] !== 1'(k % 2) || ce[1] !== 1'(k % 2)) begin
            n_err++; $display("FAIL default_ce k=%0d: got %b expected both %0d", k, ce, k % 2);
         end
      end
      n_vec++; if (cnt != 50) begin n_err++; $display("FAIL default_count: got %0d expected 50", cnt); end
   endtask

   task automatic test_ramp_up();
      int prev = DEF, last = -1, low = 0, t = 0, c;
      bit done = 0;
      apply_cfg(1, 50);
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         t++;
         c = cur_of(1);
         if (c != prev) begin
`ifdef CLKGEN_RAMP_EN
            n_vec++;
            if (c != prev + STEP || (last >= 0 && t - last != INTV)) begin
               n_err++; $display("FAIL ramp_step: got %0d after %0d cycles, expected %0d after %0d", c, t - last, prev + STEP, INTV);
            end
`endif
            last = t; prev = c;
         end
         if (!locked[1]) low++;
         if (c == 50 && locked[1]) done = 1;
      end
      n_vec++; if (!done) begin n_err++; $display("FAIL ramp_up_lock: cur %0d locked %0b expected 50/1", cur_of(1), locked[1]); end
`ifdef CLKGEN_RAMP_EN
      n_vec++; if (low < 25*INTV - 2 || low > 25*INTV + 1) begin n_err++; $display("FAIL ramp_unlocked_len: got %0d expected %0d..%0d", low, 25*INTV - 2, 25*INTV + 1); end
`else
      n_vec++; if (low != 1) begin n_err++; $display("FAIL unlocked_len: got %0d expected 1", low); end
`endif
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_vec++; if (ce[1] !== 1'b1) begin n_err++; $display("FAIL full_rate_ce1: got %0b expected 1", ce[1]); end
      end
   endtask

   task automatic test_clamp();
      bit ok; int maxv;
      apply_cfg(0, 63);
      wait_lock(0, 50, 400, ok, maxv);
      n_vec++; if (!ok) begin n_err++; $display("FAIL clamp_lock: got cur %0d expected 50", cur_of(0)); end
      n_vec++; if (maxv > 50) begin n_err++; $display("FAIL clamp_max: got %0d expected <= 50", maxv); end
   endtask

   task automatic test_zero();
      bit ok; int maxv;
      apply_cfg(0, 0);
      wait_lock(0, 0, 400, ok, maxv);
      n_vec++; if (!ok) begin n_err++; $display("FAIL zero_lock: got cur %0d expected 0", cur_of(0)); end
      @(negedge clk);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n_vec++;
         if (ce[0] !== 1'b0 || cur_of(1) !== 50 || ce[1] !== 1'b1) begin
            n_err++; $display("FAIL zero_hold: ce %b cur1 %0d expected ce 10 cur1 50", ce, cur_of(1));
         end
      end
   endtask

`ifdef CLKGEN_RAMP_EN
   task automatic test_retarget();
      bit ok; int maxv; bit hit = 0;
      apply_cfg(0, 25);
      wait_lock(0, 25, 400, ok, maxv);
      apply_cfg(0, 40);
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (cur_of(0) == 30) hit = 1;
      end
      n_vec++; if (!hit) begin n_err++; $display("FAIL retarget_reach30: got %0d expected 30", cur_of(0)); end
      apply_cfg(0, 20);
      wait_lock(0, 20, 200, ok, maxv);
      n_vec++; if (!ok) begin n_err++; $display("FAIL retarget_lock: got %0d expected 20", cur_of(0)); end
      n_vec++; if (maxv > 30) begin n_err++; $display("FAIL retarget_overshoot: got %0d expected <= 30", maxv); end
   endtask
`endif

   task automatic test_rate();
      bit ok; int maxv, ch, mhz, exp, cnt;
      int exp_cur [NUM_CH];
      for (int c = 0; c < NUM_CH; c++) exp_cur[c] = cur_of(c);
      for (int r = 0; r < 6; r++) begin
         ch  = $urandom_range(0, NUM_CH - 1);
         mhz = $urandom_range(0, 63);
         exp = (mhz > REF) ? REF : mhz;
         exp_cur[ch] = exp;
         apply_cfg(ch, mhz);
         wait_lock(ch, exp, 400, ok, maxv);
         n_vec++; if (!ok) begin n_err++; $display("FAIL rate_lock ch%0d: got %0d expected %0d", ch, cur_of(ch), exp); end
         @(negedge clk);
         cnt = 0;
         for (int i = 0; i < REF; i++) begin
            @(negedge clk);
            cnt += int'(ce[ch]);
         end
         n_vec++; if (cnt != exp) begin n_err++; $display("FAIL rate_count ch%0d: got %0d pulses expected %0d", ch, cnt, exp); end
         n_vec++; if (cur_of(1 - ch) != exp_cur[1 - ch]) begin n_err++; $display("FAIL rate_other ch%0d: got %0d expected %0d", 1 - ch, cur_of(1 - ch), exp_cur[1 - ch]); end
      end
   endtask

`ifndef CLKGEN_RAMP_EN
   task automatic test_random_model();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         n_vec++; if (cfg_ready !== m_ready) begin n_err++; $display("FAIL model_ready: got %0b expected %0b", cfg_ready, m_ready); end
         for (int c = 0; c < NUM_CH; c++) begin
            n_vec++;
            if (ce[c] !== m_ce[c] || locked[c] !== m_lock[c] || cur_of(c) !== m_cur[c]) begin
               n_err++; $display("FAIL model_ch%0d cyc %0d: got ce %0b lk %0b cur %0d expected ce %0b lk %0b cur %0d",
                                 c, i, ce[c], locked[c], cur_of(c), m_ce[c], m_lock[c], m_cur[c]);
            end
         end
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_ch    = 3'($urandom_range(0, 3));
         cfg_mhz   = SPD_W'($urandom_range(0, 63));
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      @(negedge clk);
   endtask
`endif

   task automatic test_reset_mid();
      bit ok; int maxv;
      apply_cfg(0, 20);
      wait_lock(0, 20, 400, ok, maxv);
      apply_cfg(0, 40);
`ifdef CLKGEN_RAMP_EN
      ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (cur_of(0) == 33) ok = 1;
      end
      n_vec++; if (!ok) begin n_err++; $display("FAIL mid_reach33: got %0d expected 33", cur_of(0)); end
`else
      @(negedge clk);
`endif
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (cur_of(0) !== DEF || cur_of(1) !== DEF || locked !== '0 || ce !== '0 || cfg_ready !== 1'b0) begin
         n_err++; $display("FAIL mid_reset: cur %0d/%0d lk %b ce %b rdy %0b expected %0d/%0d 00 00 0",
                           cur_of(0), cur_of(1), locked, ce, cfg_ready, DEF, DEF);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_vec++;
         if (cur_of(0) !== DEF || cur_of(1) !== DEF || locked !== 2'b11 || cfg_ready !== 1'b1) begin
            n_err++; $display("FAIL post_reset: cur %0d/%0d lk %b rdy %0b expected %0d/%0d 11 1", cur_of(0), cur_of(1), locked, cfg_ready, DEF, DEF);
         end
      end
      n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL bad_ch_ready: got %0b expected 1", cfg_ready); end
      apply_cfg(5, 10);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_vec++;
         if (cur_of(0) !== DEF || cur_of(1) !== DEF || locked !== 2'b11) begin
            n_err++; $display("FAIL bad_ch_ignored: cur %0d/%0d lk %b expected %0d/%0d 11", cur_of(0), cur_of(1), locked, DEF, DEF);
         end
      end
   endtask

   initial begin
      test_reset();
      test_default_rate();
      test_ramp_up();
      test_clamp();
      test_zero();
`ifdef CLKGEN_RAMP_EN
      test_retarget();
`endif
      test_rate();
`ifndef CLKGEN_RAMP_EN
      test_random_model();
`endif
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
